// File: rtl/sram_like_mem_if.sv
// Request/response bus of an sram-like slave port as seen from a mips inst_* or data_* port.
interface sram_like_mem_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_like_mem.sv
// Sram-like slave memory with configurable response latency, several outstanding requests,
// optional LFSR-driven addr_ok stalls, sticky misalignment flag and a one-cycle write trace.
module sram_like_mem #(
  parameter int          ADDR_BITS   = 12,
  parameter int          LATENCY     = 1,
  parameter int          OUTSTANDING = 4,
  parameter int          STALL_MODE  = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  sram_like_mem_if.slave bus,
  output logic          misalign,
  output logic          trace_valid,
  output logic [31:0]   trace_addr,
  output logic [1:0]    trace_size,
  output logic [31:0]   trace_data
);

  localparam int         PTR_W = $clog2(OUTSTANDING);
  localparam int         CNT_W = PTR_W + 1;
  localparam int         DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

  genvar gi;

  logic [15:0]            lfsr_q, lfsr_d;
  logic                   stall;
  logic                   full;
  logic                   accept;
  logic                   pop;
  logic [ADDR_BITS-1:0]   word_idx;
  logic [1:0]             a_lo;
  logic [3:0]             byte_en;
  logic [3:0]             lane_we;
  logic                   mis_acc;

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [OUTSTANDING*4-1:0] cd_flat;
  logic [3:0]             head_cnt;
  logic                   head_ready;

  logic [31:0]            mem_q [DEPTH];
  logic [31:0]            rd_word_q;
  logic [31:0]            slot_q [OUTSTANDING];
  logic                   fill_valid_q, fill_valid_d;
  logic [PTR_W-1:0]       fill_slot_q, fill_slot_d;
  logic                   fill_zero_q, fill_zero_d;
  logic [31:0]            fill_word;

  logic                   misalign_q, misalign_d;
  logic                   trace_valid_q, trace_valid_d;
  logic [31:0]            trace_addr_q, trace_addr_d;
  logic [1:0]             trace_size_q, trace_size_d;
  logic [31:0]            trace_data_q, trace_data_d;

  logic                   unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_BITS+2];

  // Accept path: fullness is judged before this cycle's pop, so a full queue never accepts.
  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    stall    = (STALL_MODE == 1) ? ~lfsr_q[0] : 1'b0;
    full     = (count_q == CNT_W'(OUTSTANDING));
    accept   = bus.req & ~full & ~stall;
    word_idx = bus.addr[ADDR_BITS+1:2];
    a_lo     = bus.addr[1:0];
    case (bus.size)
      2'd0:    byte_en = 4'b0001 << a_lo;
      2'd1:    byte_en = 4'b0011 << a_lo;
      default: byte_en = 4'b1111;
    endcase
    mis_acc  = ((bus.size == 2'd1) & a_lo[0]) | (bus.size[1] & (a_lo != 2'd0));
  end

  assign bus.addr_ok = accept;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = accept & bus.wr & byte_en[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem_q[word_idx][i*8 +: 8] <= bus.wdata[i*8 +: 8];
      end
    end
    if (accept && !bus.wr) begin
      rd_word_q <= mem_q[word_idx];
    end
  end

  // Every slot counts down independently; the head completes once its count reaches zero.
  generate
    for (gi = 0; gi < OUTSTANDING; gi++) begin : g_slot
      logic [3:0] cd_q, cd_d;

      always_comb begin
        cd_d = cd_q;
        if (accept && (wr_ptr_q == PTR_W'(gi))) begin
          cd_d = LOAD;
        end else if (cd_q != 4'd0) begin
          cd_d = cd_q - 4'd1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cd_q <= 4'd0;
        end else begin
          cd_q <= cd_d;
        end
      end

      assign cd_flat[gi*4 +: 4] = cd_q;
    end
  endgenerate

  // The registered array read lands in its slot one cycle after accept; bypass it meanwhile.
  always_comb begin
    head_cnt     = cd_flat[{rd_ptr_q, 2'b00} +: 4];
    head_ready   = (count_q != '0) && (head_cnt == 4'd0);
    pop          = head_ready;
    wr_ptr_d     = wr_ptr_q + PTR_W'(accept);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    count_d      = count_q + CNT_W'(accept) - CNT_W'(pop);
    fill_valid_d = accept;
    fill_slot_d  = wr_ptr_q;
    fill_zero_d  = bus.wr;
    fill_word    = fill_zero_q ? 32'd0 : rd_word_q;
    bus.data_ok  = head_ready;
    bus.rdata    = 32'd0;
    if (head_ready) begin
      if (fill_valid_q && (fill_slot_q == rd_ptr_q)) begin
        bus.rdata = fill_word;
      end else begin
        bus.rdata = slot_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_valid_q) begin
      slot_q[fill_slot_q] <= fill_word;
    end
  end

  always_comb begin
    misalign_d    = misalign_q | (accept & mis_acc);
    trace_valid_d = accept & bus.wr;
    trace_addr_d  = trace_addr_q;
    trace_size_d  = trace_size_q;
    trace_data_d  = trace_data_q;
    if (accept && bus.wr) begin
      trace_addr_d = bus.addr;
      trace_size_d = bus.size;
      trace_data_d = bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q        <= LFSR_SEED;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      fill_valid_q  <= 1'b0;
      fill_slot_q   <= '0;
      fill_zero_q   <= 1'b0;
      misalign_q    <= 1'b0;
      trace_valid_q <= 1'b0;
      trace_addr_q  <= 32'd0;
      trace_size_q  <= 2'd0;
      trace_data_q  <= 32'd0;
    end else begin
      lfsr_q        <= lfsr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      fill_valid_q  <= fill_valid_d;
      fill_slot_q   <= fill_slot_d;
      fill_zero_q   <= fill_zero_d;
      misalign_q    <= misalign_d;
      trace_valid_q <= trace_valid_d;
      trace_addr_q  <= trace_addr_d;
      trace_size_q  <= trace_size_d;
      trace_data_q  <= trace_data_d;
    end
  end

  assign misalign    = misalign_q;
  assign trace_valid = trace_valid_q;
  assign trace_addr  = trace_addr_q;
  assign trace_size  = trace_size_q;
  assign trace_data  = trace_data_q;

endmodule

// File: tb/tb_sram_like_mem.sv
// Scoreboard bench: three memories (plain, small/slow, stalling) driven by directed vectors.
module tb_sram_like_mem;

  localparam int LAT0 = 1;
  localparam int LAT1 = 4;
  localparam int LAT2 = 15;
  localparam int OUT2 = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_t   [3];
  logic        wr_t    [3];
  logic [1:0]  sz_t    [3];
  logic [31:0] addr_t  [3];
  logic [31:0] wdata_t [3];
  logic        ok_t    [3];
  logic        dok_t   [3];
  logic [31:0] rd_t    [3];
  logic        mis_t   [3];
  logic        tv_t    [3];
  logic [31:0] ta_t    [3];
  logic [1:0]  ts_t    [3];
  logic [31:0] td_t    [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   acc2[$];
  logic [15:0] ref_lfsr;

  sram_like_mem_if bus0();
  sram_like_mem_if bus1();
  sram_like_mem_if bus2();

  assign bus0.req = req_t[0];  assign bus0.wr = wr_t[0];  assign bus0.size = sz_t[0];
  assign bus0.addr = addr_t[0]; assign bus0.wdata = wdata_t[0];
  assign ok_t[0] = bus0.addr_ok; assign dok_t[0] = bus0.data_ok; assign rd_t[0] = bus0.rdata;
  assign bus1.req = req_t[1];  assign bus1.wr = wr_t[1];  assign bus1.size = sz_t[1];
  assign bus1.addr = addr_t[1]; assign bus1.wdata = wdata_t[1];
  assign ok_t[1] = bus1.addr_ok; assign dok_t[1] = bus1.data_ok; assign rd_t[1] = bus1.rdata;
  assign bus2.req = req_t[2];  assign bus2.wr = wr_t[2];  assign bus2.size = sz_t[2];
  assign bus2.addr = addr_t[2]; assign bus2.wdata = wdata_t[2];
  assign ok_t[2] = bus2.addr_ok; assign dok_t[2] = bus2.data_ok; assign rd_t[2] = bus2.rdata;

  sram_like_mem #(.ADDR_BITS(12), .LATENCY(LAT0), .OUTSTANDING(4), .STALL_MODE(0),
                  .LFSR_SEED(16'hACE1)) u0 (
    .clk(clk), .rst(rst), .bus(bus0), .misalign(mis_t[0]), .trace_valid(tv_t[0]),
    .trace_addr(ta_t[0]), .trace_size(ts_t[0]), .trace_data(td_t[0]));

  sram_like_mem #(.ADDR_BITS(4), .LATENCY(LAT1), .OUTSTANDING(4), .STALL_MODE(0),
                  .LFSR_SEED(16'hACE1)) u1 (
    .clk(clk), .rst(rst), .bus(bus1), .misalign(mis_t[1]), .trace_valid(tv_t[1]),
    .trace_addr(ta_t[1]), .trace_size(ts_t[1]), .trace_data(td_t[1]));

  sram_like_mem #(.ADDR_BITS(12), .LATENCY(LAT2), .OUTSTANDING(OUT2), .STALL_MODE(1),
                  .LFSR_SEED(16'hACE1)) u2 (
    .clk(clk), .rst(rst), .bus(bus2), .misalign(mis_t[2]), .trace_valid(tv_t[2]),
    .trace_addr(ta_t[2]), .trace_size(ts_t[2]), .trace_data(td_t[2]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : ((d == 1) ? LAT1 : LAT2);
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // x^16+x^14+x^13+x^11 Galois step written out bit by bit
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    logic [15:0] n;
    n[15]  = s[0];
    n[14]  = s[15];
    n[13]  = s[14] ^ s[0];
    n[12]  = s[13] ^ s[0];
    n[11]  = s[12];
    n[10]  = s[11] ^ s[0];
    n[9:0] = s[10:1];
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) ref_lfsr <= 16'hACE1;
    else     ref_lfsr <= ref_next(ref_lfsr);
  end

  task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] expd, output int acc);
    bit   got;
    exp_t e;
    got = 1'b0;
    acc = -1;
    req_t[d] = 1'b1; wr_t[d] = w; sz_t[d] = sz; addr_t[d] = a; wdata_t[d] = wd;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (ok_t[d]) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d addr %h: got addr_ok=0, want 1 within 400 cycles", d, a);
      req_t[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    e.data = expd;
    e.acc  = 32'(cyc);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    req_t[d] = 1'b0;
    $display("dut%0d accept %s size=%0d addr=%h wdata=%h cycle=%0d", d, w ? "wr" : "rd", sz, a, wd, cyc);
  endtask

  task automatic drain(input int d);
    for (int n = 0; n < 300 && qsize(d) != 0; n++) @(negedge clk);
    if (qsize(d) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout dut%0d: got %0d pending, want 0", d, qsize(d));
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Completion monitor: pops the scoreboard on every data_ok and checks data and latency.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (dok_t[d]) begin
          exp_t e;
          bit   have;
          int   dt;
          have = 1'b0;
          case (d)
            0:       if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
          endcase
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_data_ok dut%0d: got data_ok=1 (rdata %h), want 0", d, rd_t[d]);
          end else begin
            dt = cyc - int'(e.acc);
            chk($sformatf("rdata_dut%0d", d), rd_t[d], e.data);
            chk($sformatf("latency_dut%0d", d), 32'(dt), 32'(lat_of(d) - 1));
            $display("dut%0d complete rdata=%h expected=%h cycle=%0d", d, rd_t[d], e.data, cyc);
          end
        end
      end
    end
  end

  // Stalling instance: addr_ok must follow the reference LFSR and the bench's own occupancy count.
  always @(negedge clk) begin
    if (rst) begin
      acc2.delete();
    end else begin
      int   occ;
      logic exp_ok;
      occ = 0;
      foreach (acc2[i]) if (acc2[i] <= cyc && acc2[i] > cyc - LAT2) occ++;
      while (acc2.size() > 0 && acc2[0] <= cyc - LAT2) void'(acc2.pop_front());
      exp_ok = req_t[2] && ref_lfsr[0] && (occ < OUT2);
      chk("addr_ok_dut2", 32'(ok_t[2]), 32'(exp_ok));
      if (exp_ok) acc2.push_back(cyc + 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int bp_acc[6];
    int bp_gap[6];
    bp_gap = '{0, 1, 2, 3, 5, 6};
    for (int d = 0; d < 3; d++) begin
      req_t[d] = 1'b0; wr_t[d] = 1'b0; sz_t[d] = 2'd0; addr_t[d] = 32'd0; wdata_t[d] = 32'd0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_ok", 32'(ok_t[0]), 32'd0);
    chk("rst_data_ok", 32'(dok_t[0]), 32'd0);
    chk("rst_rdata", rd_t[0], 32'd0);
    chk("rst_misalign", 32'(mis_t[0]), 32'd0);
    chk("rst_trace_valid", 32'(tv_t[0]), 32'd0);
    chk("rst_trace_addr", ta_t[0], 32'd0);
    chk("rst_trace_size", 32'(ts_t[0]), 32'd0);
    chk("rst_trace_data", td_t[0], 32'd0);
    chk("rst_data_ok_dut1", 32'(dok_t[1]), 32'd0);
    chk("rst_data_ok_dut2", 32'(dok_t[2]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Word write, trace pulse, read-after-write
    issue(0, 1'b1, 2'd2, 32'h100, 32'h12345678, 32'd0, a);
    chk("trace_valid", 32'(tv_t[0]), 32'd1);
    chk("trace_addr", ta_t[0], 32'h100);
    chk("trace_size", 32'(ts_t[0]), 32'd2);
    chk("trace_data", td_t[0], 32'h12345678);
    issue(0, 1'b0, 2'd2, 32'h100, 32'd0, 32'h12345678, a);
    chk("trace_valid_after_read", 32'(tv_t[0]), 32'd0);

    // Byte and half lanes
    issue(0, 1'b1, 2'd2, 32'h40, 32'h00000000, 32'd0, a);
    issue(0, 1'b1, 2'd0, 32'h41, 32'h0000AB00, 32'd0, a);
    issue(0, 1'b1, 2'd1, 32'h42, 32'hCDEF0000, 32'd0, a);
    issue(0, 1'b0, 2'd2, 32'h40, 32'd0, 32'hCDEFAB00, a);
    chk("misalign_aligned", 32'(mis_t[0]), 32'd0);

    // Misaligned half at 0x43 only reaches lane 3
    issue(0, 1'b1, 2'd1, 32'h43, 32'h11223344, 32'd0, a);
    chk("misalign_set", 32'(mis_t[0]), 32'd1);
    issue(0, 1'b0, 2'd2, 32'h40, 32'd0, 32'h11EFAB00, a);
    for (int i = 0; i < 100; i++) begin
      issue(0, 1'b0, 2'd2, 32'h100, 32'd0, 32'h12345678, a);
      chk("misalign_sticky", 32'(mis_t[0]), 32'd1);
    end
    drain(0);

    // Address wrap with ADDR_BITS=4
    issue(1, 1'b1, 2'd2, 32'h40, 32'hDEADBEEF, 32'd0, a);
    issue(1, 1'b0, 2'd2, 32'h00, 32'd0, 32'hDEADBEEF, a);
    drain(1);

    // Backpressure: six back-to-back reads into a 4-deep queue with latency 4
    for (int i = 0; i < 6; i++) issue(1, 1'b1, 2'd2, 32'(4 * i), 32'hA5000000 | 32'(i), 32'd0, a);
    drain(1);
    for (int i = 0; i < 6; i++) issue(1, 1'b0, 2'd2, 32'(4 * i), 32'd0, 32'hA5000000 | 32'(i), bp_acc[i]);
    for (int i = 0; i < 6; i++) chk($sformatf("bp_accept_gap%0d", i), 32'(bp_acc[i] - bp_acc[0]), 32'(bp_gap[i]));
    drain(1);

    // Stalling instance: three reads in flight, then reset drops them
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("misalign_cleared_by_rst", 32'(mis_t[0]), 32'd0);
    for (int i = 0; i < 3; i++) issue(2, 1'b0, 2'd2, 32'(4 * i), 32'd0, 32'd0, a);
    rst = 1'b1;
    q2.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("no_data_ok_after_rst", 32'(dok_t[2]), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) issue(2, 1'b1, 2'd2, 32'h300 + 32'(4 * i), 32'h5A5A0000 + 32'(i), 32'd0, a);
    for (int i = 0; i < 8; i++) issue(2, 1'b0, 2'd2, 32'h300 + 32'(4 * i), 32'd0, 32'h5A5A0000 + 32'(i), a);
    drain(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
